// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and bus request type for the UART TX peripheral.
package uart_pkg;

  // register offsets, indexed by mem_addr[3:2]
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;

  // STAT bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 8;

  // smallest divisor the bit timer accepts
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  typedef struct packed {
    logic [1:0]  off;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_req_t;

  // byte-lane merge of a DIV write, clamped to DIV_MIN
  function automatic logic [15:0] div_merge(input logic [15:0] cur,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  wstrb);
    logic [15:0] v;
    v = cur;
    if (wstrb[0]) v[7:0]  = wdata[7:0];
    if (wstrb[1]) v[15:8] = wdata[15:8];
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word fall-through read port.
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 cnt;
  logic                        do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rd_ptr];

  // storage array: written on accepted push, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus.
// uart_tx is registered from the FSM output, so line activity trails the
// state by one cycle; each state still lasts exactly DIV cycles.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        irq_tx_empty
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  bus_req_t    req;
  logic        acc, push, pop, ovf, busy, tx_d;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [LW-1:0] fifo_level;
  logic [15:0] div, cnt, reload;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        bit_end;
  logic [31:0] rd_val;
  tx_state_e   state, state_n;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

  assign req  = '{off: mem_addr[3:2], wr: |mem_wstrb, wstrb: mem_wstrb, wdata: mem_wdata};
  assign acc  = mem_valid && !mem_ready;
  assign push = acc && req.off == REG_DATA && req.wstrb[0];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (req.wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // read mux, sampled into mem_rdata on the acknowledging edge
  always_comb begin
    rd_val = '0;
    case (req.off)
      REG_STAT: begin
        rd_val[STAT_FULL]             = fifo_full;
        rd_val[STAT_EMPTY]            = fifo_empty;
        rd_val[STAT_BUSY]             = busy;
        rd_val[STAT_OVF]              = ovf;
        rd_val[STAT_LVL_LSB +: LW]    = fifo_level;
      end
      REG_DIV:  rd_val[15:0] = div;
      default:  rd_val = '0;
    endcase
  end

  // bus handshake and register writes; everything commits as ready rises
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      div       <= DIV_RESET;
      ovf       <= 1'b0;
    end else begin
      mem_ready <= acc;
      mem_rdata <= acc ? rd_val : '0;
      if (acc && req.wr && req.off == REG_DIV)
        div <= div_merge(div, req.wdata, req.wstrb);
      if (push && fifo_full && !pop)
        ovf <= 1'b1;
      else if (acc && req.off == REG_STAT && req.wstrb[0] && req.wdata[STAT_OVF])
        ovf <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  assign bit_end = (cnt == '0);

  // next state; a pop from STOP chains straight into the next START
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE:  if (!fifo_empty) begin pop = 1'b1; state_n = ST_START; end
      ST_START: if (bit_end) state_n = ST_DATA;
      ST_DATA:  if (bit_end && bit_idx == 3'd7) state_n = ST_STOP;
      ST_STOP:  if (bit_end) begin
                  if (!fifo_empty) begin pop = 1'b1; state_n = ST_START; end
                  else state_n = ST_IDLE;
                end
      default:  state_n = ST_IDLE;
    endcase
  end

  // FSM outputs: line level for the current state, busy flag
  always_comb begin
    tx_d = 1'b1;
    busy = (state != ST_IDLE);
    case (state)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // bit timer, shift register and registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      reload  <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
    end else begin
      uart_tx <= tx_d;
      if (pop) begin
        shreg   <= fifo_dout;
        reload  <= div;
        cnt     <= div - 1'b1;
        bit_idx <= '0;
      end else if (state != ST_IDLE) begin
        if (bit_end) begin
          cnt <= reload - 1'b1;
          if (state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign irq_tx_empty = fifo_empty && (state == ST_IDLE);

endmodule
